// File: rtl/axil_uart_responder.sv
// AXI4-Lite register front end for a UART byte path: DATA/STATUS/IER/SCRATCH with TX and RX byte FIFOs.
// Latency: read data one cycle after the AR handshake; write response one cycle after both AW and W are held.
// Backpressure: AW/W/AR stall while a response is outstanding; TX drains on tx_ready; RX has none (drops on full).
//
// Ports:
//   chipset_clk, chipset_rst_n      clock, synchronous active-low reset
//   s_axi_aw*/w*/b*/ar*/r*          AXI4-Lite slave, 13-bit address, 32-bit data
//   tx_data/tx_valid/tx_ready       byte stream out to the serializer (TX FIFO head)
//   rx_data/rx_valid                byte stream in from the deserializer
//   uart_irq                        registered level interrupt

// Generic byte FIFO. A push is accepted when not full or when a pop happens in the
// same cycle, so a full FIFO can be pushed and popped together.
module axil_uart_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         empty,
  output logic         full
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic          do_push, do_pop;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == FULL_CNT);
  assign head_dat = mem_q[rd_ptr_q];
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
    else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: it is only observed through a non-zero count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

module axil_uart_responder #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        chipset_clk,
  input  logic        chipset_rst_n,
  input  logic [12:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [12:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        uart_irq
);
  localparam logic [10:0] IDX_DATA    = 11'd0;
  localparam logic [10:0] IDX_STATUS  = 11'd1;
  localparam logic [10:0] IDX_IER     = 11'd2;
  localparam logic [10:0] IDX_SCRATCH = 11'd3;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  // init_q holds the ready outputs low through reset and raises them on the first edge after.
  logic        init_q, init_d;
  logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [10:0] aw_idx_q, aw_idx_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  ier_q, ier_d;
  logic [31:0] scratch_q, scratch_d;
  logic        overrun_q, overrun_d;
  logic        irq_q, irq_d;

  logic        aw_fire, w_fire, ar_fire, wr_fire;
  logic [10:0] ar_idx;
  logic        tx_push, tx_pop, tx_drop, tx_empty, tx_full;
  logic        rx_pop, rx_drop, rx_empty, rx_full;
  logic [7:0]  rx_head;
  logic [31:0] status;
  logic        unused_addr_lsbs;

  assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign s_axi_awready = init_q & ~aw_held_q & ~bvalid_q;
  assign s_axi_wready  = init_q & ~w_held_q & ~bvalid_q;
  assign s_axi_arready = init_q & ~rvalid_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign uart_irq      = irq_q;

  assign aw_fire = s_axi_awvalid & s_axi_awready;
  assign w_fire  = s_axi_wvalid & s_axi_wready;
  assign ar_fire = s_axi_arvalid & s_axi_arready;
  assign wr_fire = aw_held_q & w_held_q;
  assign ar_idx  = s_axi_araddr[12:2];

  assign tx_valid = ~tx_empty;
  assign tx_pop   = tx_valid & tx_ready;
  assign tx_push  = wr_fire & (aw_idx_q == IDX_DATA) & wstrb_q[0];
  // A full TX still takes the byte if the serializer pops in the same cycle.
  assign tx_drop  = tx_push & tx_full & ~tx_pop;

  assign rx_pop   = ar_fire & (ar_idx == IDX_DATA) & ~rx_empty;
  assign rx_drop  = rx_valid & rx_full & ~rx_pop;

  assign status = {27'b0, overrun_q, tx_full, tx_empty, rx_full, ~rx_empty};

  axil_uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
    .clk(chipset_clk), .rst_n(chipset_rst_n),
    .push(tx_push), .push_dat(wdata_q[7:0]), .pop(tx_pop),
    .head_dat(tx_data), .empty(tx_empty), .full(tx_full)
  );

  axil_uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
    .clk(chipset_clk), .rst_n(chipset_rst_n),
    .push(rx_valid), .push_dat(rx_data), .pop(rx_pop),
    .head_dat(rx_head), .empty(rx_empty), .full(rx_full)
  );

  always_comb begin
    init_d    = 1'b1;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    aw_idx_d  = aw_idx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    ier_d     = ier_q;
    scratch_d = scratch_q;

    if (aw_fire) begin
      aw_held_d = 1'b1;
      aw_idx_d  = s_axi_awaddr[12:2];
    end
    if (w_fire) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi_wdata;
      wstrb_d  = s_axi_wstrb;
    end

    if (bvalid_q && s_axi_bready) bvalid_d = 1'b0;
    if (wr_fire) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = RESP_OKAY;
      case (aw_idx_q)
        IDX_DATA:    if (tx_drop) bresp_d = RESP_SLVERR;
        IDX_STATUS:  ;
        IDX_IER:     if (wstrb_q[0]) ier_d = wdata_q[1:0];
        IDX_SCRATCH: begin
          for (int b = 0; b < 4; b++) begin
            if (wstrb_q[b]) scratch_d[8*b +: 8] = wdata_q[8*b +: 8];
          end
        end
        default:     bresp_d = RESP_SLVERR;
      endcase
    end

    if (rvalid_q && s_axi_rready) rvalid_d = 1'b0;
    if (ar_fire) begin
      rvalid_d = 1'b1;
      rresp_d  = RESP_OKAY;
      rdata_d  = '0;
      case (ar_idx)
        IDX_DATA:    rdata_d = rx_empty ? 32'd0 : {24'b0, rx_head};
        IDX_STATUS:  rdata_d = status;
        IDX_IER:     rdata_d = {30'b0, ier_q};
        IDX_SCRATCH: rdata_d = scratch_q;
        default:     rresp_d = RESP_SLVERR;
      endcase
    end
  end

  // A drop in the same cycle as a STATUS read keeps the flag set.
  assign overrun_d = (overrun_q & ~(ar_fire & (ar_idx == IDX_STATUS))) | rx_drop;
  assign irq_d     = (ier_q[0] & ~rx_empty) | (ier_q[1] & tx_empty);

  always_ff @(posedge chipset_clk) begin
    if (!chipset_rst_n) begin
      init_q    <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      ier_q     <= '0;
      scratch_q <= '0;
      overrun_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      init_q    <= init_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_idx_q  <= aw_idx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      ier_q     <= ier_d;
      scratch_q <= scratch_d;
      overrun_q <= overrun_d;
      irq_q     <= irq_d;
    end
  end
endmodule

// File: tb/tb_axil_uart_responder.sv
// Directed bench for axil_uart_responder: register table plus hand-timed FIFO, IRQ and handshake sequences.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled at the same point.
// Backpressure: bready/rready/tx_ready are driven explicitly per sequence.
module tb_axil_uart_responder;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, uart_irq;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axil_uart_responder #(.FIFO_DEPTH(D)) dut (
    .chipset_clk(clk), .chipset_rst_n(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .uart_irq(uart_irq)
  );

  typedef struct {
    bit          is_wr;
    logic [12:0] addr;
    logic [31:0] wdat;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[17];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timeout waiting on DUT", name);
  endtask

  task automatic axi_write(input logic [12:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] r);
    logic aw_f, w_f;
    int n;
    n = 0;
    r = 2'bxx;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    while ((awvalid || wvalid) && n < 50) begin
      aw_f = awvalid & awready;
      w_f  = wvalid & wready;
      step(); n++;
      if (aw_f) awvalid = 1'b0;
      if (w_f)  wvalid  = 1'b0;
    end
    while (!bvalid && n < 50) begin step(); n++; end
    if (n >= 50) begin
      timeout("axi_write");
      awvalid = 1'b0; wvalid = 1'b0;
    end else begin
      r = bresp;
    end
    step();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [12:0] a, output logic [31:0] d, output logic [1:0] r);
    int n;
    n = 0;
    d = 'x; r = 2'bxx;
    araddr = a; arvalid = 1'b1; rready = 1'b0;
    while (!arready && n < 50) begin step(); n++; end
    step();
    arvalid = 1'b0;
    chk("rd_latency_rvalid", {31'b0, rvalid}, 32'd1);
    while (!rvalid && n < 50) begin step(); n++; end
    if (n >= 50) begin
      timeout("axi_read");
    end else begin
      d = rdata; r = rresp;
    end
    rready = 1'b1;
    step();
    rready = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [12:0] a, input logic [31:0] exp_d,
                        input logic [1:0] exp_r);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(a, d, r);
    chk({name, "_rdata"}, d, exp_d);
    chk({name, "_rresp"}, {30'b0, r}, {30'b0, exp_r});
  endtask

  task automatic wr_chk(input string name, input logic [12:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [1:0] exp_r);
    logic [1:0] r;
    axi_write(a, d, s, r);
    chk({name, "_bresp"}, {30'b0, r}, {30'b0, exp_r});
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_tx [D];
    logic [7:0] exp_rx [D];

    rst_n = 1'b0;
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    araddr = '0; arvalid = 0; rready = 0; tx_ready = 0; rx_data = '0; rx_valid = 0;

    //       wr    addr      wdata          strb     exp_rdata      resp
    vecs[0]  = '{0, 13'h004, 32'h0,         4'h0, 32'h0000_0004, 2'b00};
    vecs[1]  = '{0, 13'h00C, 32'h0,         4'h0, 32'h0000_0000, 2'b00};
    vecs[2]  = '{0, 13'h008, 32'h0,         4'h0, 32'h0000_0000, 2'b00};
    vecs[3]  = '{1, 13'h00C, 32'hA5A5_1234, 4'h3, 32'h0,         2'b00};
    vecs[4]  = '{0, 13'h00C, 32'h0,         4'h0, 32'h0000_1234, 2'b00};
    vecs[5]  = '{1, 13'h00E, 32'hFFEE_DDCC, 4'hC, 32'h0,         2'b00};
    vecs[6]  = '{0, 13'h00F, 32'h0,         4'h0, 32'hFFEE_1234, 2'b00};
    vecs[7]  = '{1, 13'h008, 32'hFFFF_FFFF, 4'hF, 32'h0,         2'b00};
    vecs[8]  = '{0, 13'h00A, 32'h0,         4'h0, 32'h0000_0003, 2'b00};
    vecs[9]  = '{1, 13'h008, 32'h0,         4'hF, 32'h0,         2'b00};
    vecs[10] = '{0, 13'h010, 32'h0,         4'h0, 32'h0,         2'b10};
    vecs[11] = '{1, 13'h010, 32'h1234_5678, 4'hF, 32'h0,         2'b10};
    vecs[12] = '{1, 13'h1FC, 32'h0000_00AA, 4'hF, 32'h0,         2'b10};
    vecs[13] = '{0, 13'h00C, 32'h0,         4'h0, 32'hFFEE_1234, 2'b00};
    vecs[14] = '{0, 13'h000, 32'h0,         4'h0, 32'h0,         2'b00};
    vecs[15] = '{1, 13'h004, 32'hFF,        4'hF, 32'h0,         2'b00};
    vecs[16] = '{1, 13'h000, 32'h55,        4'h0, 32'h0,         2'b00};

    // Reset state and ready rise.
    repeat (3) step();
    chk("rst_awready", {31'b0, awready}, 0);
    chk("rst_wready", {31'b0, wready}, 0);
    chk("rst_arready", {31'b0, arready}, 0);
    chk("rst_bvalid", {31'b0, bvalid}, 0);
    chk("rst_rvalid", {31'b0, rvalid}, 0);
    chk("rst_tx_valid", {31'b0, tx_valid}, 0);
    chk("rst_irq", {31'b0, uart_irq}, 0);
    rst_n = 1'b1;
    chk("rdy_before_edge", {31'b0, arready}, 0);
    step();
    chk("rdy_awready", {31'b0, awready}, 1);
    chk("rdy_wready", {31'b0, wready}, 1);
    chk("rdy_arready", {31'b0, arready}, 1);

    // Register table.
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].is_wr)
        wr_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdat, vecs[i].strb, vecs[i].exp_resp);
      else
        rd_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_rdata, vecs[i].exp_resp);
    end
    rd_chk("status_after_table", 13'h004, 32'h4, 2'b00);

    // Single TX byte.
    wr_chk("tx41", 13'h000, 32'h41, 4'h1, 2'b00);
    chk("tx41_valid", {31'b0, tx_valid}, 1);
    chk("tx41_data", {24'b0, tx_data}, 32'h41);
    rd_chk("tx41_status", 13'h004, 32'h0, 2'b00);
    tx_ready = 1'b1; step(); tx_ready = 1'b0;
    chk("tx41_drained", {31'b0, tx_valid}, 0);

    // TX full, drop on overflow, then push+pop while full.
    for (int i = 0; i < D; i++) wr_chk($sformatf("txfill%0d", i), 13'h000, 32'h10 + i, 4'h1, 2'b00);
    wr_chk("tx_overflow", 13'h000, 32'h99, 4'h1, 2'b10);
    rd_chk("tx_full_status", 13'h004, 32'h8, 2'b00);
    awaddr = 13'h000; wdata = 32'h55; wstrb = 4'h1; awvalid = 1; wvalid = 1; bready = 1;
    step();
    awvalid = 0; wvalid = 0; tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    chk("tx_pp_bvalid", {31'b0, bvalid}, 1);
    chk("tx_pp_bresp", {30'b0, bresp}, 0);
    step();
    bready = 0;
    rd_chk("tx_pp_status", 13'h004, 32'h8, 2'b00);
    for (int i = 0; i < D - 1; i++) exp_tx[i] = 8'(8'h11 + i);
    exp_tx[D-1] = 8'h55;
    for (int i = 0; i < D; i++) begin
      chk($sformatf("tx_drain%0d_valid", i), {31'b0, tx_valid}, 1);
      chk($sformatf("tx_drain%0d_data", i), {24'b0, tx_data}, {24'b0, exp_tx[i]});
      tx_ready = 1'b1; step(); tx_ready = 1'b0;
    end
    chk("tx_drain_empty", {31'b0, tx_valid}, 0);

    // RX overrun and in-order readback.
    for (int i = 0; i <= D; i++) rx_push(8'(8'h60 + i));
    rd_chk("rx_ovr_status", 13'h004, 32'h17, 2'b00);
    rd_chk("rx_ovr_cleared", 13'h004, 32'h07, 2'b00);
    for (int i = 0; i < D; i++) rd_chk($sformatf("rx_pop%0d", i), 13'h000, 32'h60 + i, 2'b00);
    rd_chk("rx_empty_status", 13'h004, 32'h04, 2'b00);
    rd_chk("rx_empty_read", 13'h000, 32'h0, 2'b00);

    // RX push+pop while full: both happen, no overrun.
    for (int i = 0; i < D; i++) rx_push(8'(8'h70 + i));
    araddr = 13'h000; arvalid = 1; rx_data = 8'h7A; rx_valid = 1;
    step();
    arvalid = 0; rx_valid = 0;
    chk("rx_pp_rvalid", {31'b0, rvalid}, 1);
    chk("rx_pp_rdata", rdata, 32'h70);
    rready = 1; step(); rready = 0;
    rd_chk("rx_pp_status", 13'h004, 32'h07, 2'b00);

    // Overrun set in the same cycle as a STATUS read wins.
    araddr = 13'h004; arvalid = 1; rx_data = 8'hEE; rx_valid = 1;
    step();
    arvalid = 0; rx_valid = 0;
    chk("ovr_race_rdata", rdata, 32'h07);
    rready = 1; step(); rready = 0;
    rd_chk("ovr_race_sticky", 13'h004, 32'h17, 2'b00);
    rd_chk("ovr_race_clear", 13'h004, 32'h07, 2'b00);
    exp_rx[0] = 8'h71; exp_rx[1] = 8'h72; exp_rx[2] = 8'h73; exp_rx[3] = 8'h7A;
    for (int i = 0; i < D; i++)
      rd_chk($sformatf("rx_pp_pop%0d", i), 13'h000, {24'b0, exp_rx[i]}, 2'b00);

    // RX interrupt timing.
    wr_chk("ier_rx", 13'h008, 32'h1, 4'h1, 2'b00);
    chk("irq_idle", {31'b0, uart_irq}, 0);
    rx_push(8'h7E);
    chk("irq_push_plus0", {31'b0, uart_irq}, 0);
    step();
    chk("irq_push_plus1", {31'b0, uart_irq}, 1);
    araddr = 13'h000; arvalid = 1;
    step();
    arvalid = 0;
    chk("irq_pop_plus0", {31'b0, uart_irq}, 1);
    chk("irq_rdata", rdata, 32'h7E);
    rready = 1; step(); rready = 0;
    chk("irq_pop_plus1", {31'b0, uart_irq}, 0);
    wr_chk("ier_off", 13'h008, 32'h0, 4'h1, 2'b00);

    // W ahead of AW, stalled bready, concurrent unmapped read.
    wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1; bready = 0;
    step();
    wvalid = 0;
    chk("w_first_wready", {31'b0, wready}, 0);
    step(); step();
    awaddr = 13'h00C; awvalid = 1; araddr = 13'h1FC; arvalid = 1; rready = 0;
    step();
    awvalid = 0; arvalid = 0;
    chk("conc_rvalid", {31'b0, rvalid}, 1);
    chk("conc_rresp", {30'b0, rresp}, 32'h2);
    chk("conc_rdata", rdata, 32'h0);
    chk("conc_bvalid_early", {31'b0, bvalid}, 0);
    rready = 1;
    step();
    rready = 0;
    chk("conc_rvalid_done", {31'b0, rvalid}, 0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall%0d_bvalid", i), {31'b0, bvalid}, 1);
      chk($sformatf("stall%0d_bresp", i), {30'b0, bresp}, 0);
      chk($sformatf("stall%0d_awready", i), {31'b0, awready}, 0);
      step();
    end
    bready = 1; step(); bready = 0;
    chk("stall_bvalid_done", {31'b0, bvalid}, 0);
    rd_chk("stall_scratch", 13'h00C, 32'hDEAD_BEEF, 2'b00);

    // Reset with a held AW and a pending read response.
    awaddr = 13'h00C; awvalid = 1;
    step();
    awvalid = 0;
    araddr = 13'h008; arvalid = 1;
    step();
    arvalid = 0;
    chk("mid_rvalid_pending", {31'b0, rvalid}, 1);
    rst_n = 0;
    step();
    rst_n = 1;
    chk("mid_rvalid_gone", {31'b0, rvalid}, 0);
    chk("mid_bvalid_gone", {31'b0, bvalid}, 0);
    chk("mid_awready_low", {31'b0, awready}, 0);
    step();
    chk("mid_awready_up", {31'b0, awready}, 1);
    wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1; bready = 1;
    step();
    wvalid = 0;
    step(); step();
    chk("mid_no_bvalid", {31'b0, bvalid}, 0);
    rd_chk("mid_scratch_reset", 13'h00C, 32'h0, 2'b00);
    awaddr = 13'h00C; awvalid = 1;
    step();
    awvalid = 0;
    step();
    chk("mid_late_bvalid", {31'b0, bvalid}, 1);
    step();
    bready = 0;
    rd_chk("mid_scratch_new", 13'h00C, 32'h1234_5678, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axil_uart_responder.md
AXIL_UART_RESPONDER -- requirements
Module: axil_uart_responder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16: TX and RX FIFO entries; power of 2, at least 2.
REQ-002 SHALL have port chipset_clk, input, 1: sole clock; all logic on the rising edge.
REQ-003 SHALL have port chipset_rst_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have ports s_axi_awaddr/awvalid/awready, in/in/out, 13/1/1: AXI4-Lite write address.
REQ-005 SHALL have ports s_axi_wdata/wstrb/wvalid/wready, in/in/in/out, 32/4/1/1: write data.
REQ-006 SHALL have ports s_axi_bresp/bvalid/bready, out/out/in, 2/1/1: write response.
REQ-007 SHALL have ports s_axi_araddr/arvalid/arready, in/in/out, 13/1/1: read address.
REQ-008 SHALL have ports s_axi_rdata/rresp/rvalid/rready, out/out/out/in, 32/2/1/1: read data.
REQ-009 SHALL have ports tx_data/tx_valid/tx_ready, out/out/in, 8/1/1: byte stream to the serializer.
REQ-010 SHALL have ports rx_data/rx_valid, in/in, 8/1: byte stream from the deserializer; no backpressure.
REQ-011 SHALL have port uart_irq, output, 1: registered level interrupt.

Function
REQ-012 Address decode SHALL use addr[12:2] only; addr[1:0] are ignored.
REQ-013 Register map SHALL be:
- 0x000 DATA: read pops RX; write pushes wdata[7:0] to TX when wstrb[0]=1.
- 0x004 STATUS, RO: bit0 rx_nonempty, bit1 rx_full, bit2 tx_empty, bit3 tx_full, bit4 rx_overrun.
- 0x008 IER, RW bits[1:0].
- 0x00C SCRATCH, RW 32 bits, byte-strobed.
REQ-014 Access to any other address SHALL respond SLVERR (2'b10) with rdata=0 and no side effect; all other responses SHALL be OKAY (2'b00).
REQ-015 AW and W SHALL be accepted independently; awready (or wready) SHALL be high while its beat is not yet held and bvalid=0.
REQ-016 When both AW and W are held, the register effect SHALL apply and bvalid SHALL assert on the next cycle; bvalid SHALL hold with a stable bresp until bready.
REQ-017 arready SHALL be high when rvalid=0; after an AR handshake, rvalid SHALL assert on the next cycle with rdata/rresp stable until rready.
REQ-018 Read and write channels SHALL operate concurrently.
REQ-019 A DATA write with TX full SHALL drop the byte and return SLVERR.
REQ-020 A DATA read with RX empty SHALL return 0 with OKAY and SHALL NOT pop.
REQ-021 A DATA read SHALL pop exactly one entry, at the AR handshake; rdata SHALL be {24'b0, byte}.
REQ-022 tx_valid SHALL equal TX non-empty; tx_data SHALL be the TX head; the head pops when tx_valid & tx_ready.
REQ-023 A TX push and pop in the same cycle SHALL both occur; the count is unchanged, including when TX is full.
REQ-024 rx_valid with RX not full SHALL push rx_data.
REQ-025 rx_valid with RX full SHALL drop the byte and set rx_overrun.
REQ-026 A same-cycle RX push and pop with RX full SHALL both occur, with no overrun.
REQ-027 rx_overrun SHALL be sticky and SHALL clear on a STATUS read handshake; a same-cycle set SHALL win over the clear.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be derived from a log2(FIFO_DEPTH)+1-bit occupancy count.
REQ-029 uart_irq SHALL register (IER[0] & rx_nonempty) | (IER[1] & tx_empty), giving one cycle of latency.

Reset
REQ-030 While chipset_rst_n=0 at a clock edge, the block SHALL set: FIFOs empty; IER=0; SCRATCH=0; rx_overrun=0; bvalid=rvalid=tx_valid=uart_irq=0; awready=wready=arready=0.
REQ-031 Ready outputs SHALL rise on the first edge after reset deasserts.
REQ-032 Reset mid-transaction SHALL discard held AW/W beats and pending responses without emitting them.

Verification
REQ-033 Write 0x00C data 0xA5A5_1234 with wstrb 4'b0011, then read 0x00C -> rdata 0x0000_1234, OKAY, rvalid one cycle after AR.
REQ-034 Write 0x000 with 0x41, tx_ready=0 -> tx_valid=1, tx_data=0x41, STATUS bit2=0; set tx_ready=1 for one cycle -> tx_valid=0.
REQ-035 Push FIFO_DEPTH bytes into TX, then write 0x000 once more -> SLVERR; STATUS=0x08.
REQ-036 Inject FIFO_DEPTH+1 rx bytes -> STATUS bit4=1; read STATUS again -> bit4=0; DATA reads return the first FIFO_DEPTH bytes in order.
REQ-037 Set IER=0x1, inject rx byte 0x7E -> uart_irq=1 one cycle after the push; DATA read returns 0x7E, and uart_irq=0 one cycle after the pop.
REQ-038 Present W three cycles before AW, stall bready for five cycles, and read 0x1FC -> bvalid/bresp stable while stalled; read returns SLVERR, rdata 0.
